ps2_device_tx: RTL and testbench

PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

---
 rtl/ps2_device_tx.sv | 177 +++++++++++++++++
 tb/tb_ps2_device_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// ps2_device_tx
//   Device-side PS/2 transmitter with a small byte FIFO. Bytes written on
//   data_in are queued and sent one at a time as 11-bit PS/2 frames
//   (start 0, data LSB first, odd parity, stop 1). The device generates both
//   lines itself. A fixed idle gap separates consecutive frames.
//
// Ports
//   clk        in   single clock, all logic on its rising edge
//   clrn       in   synchronous active-low reset
//   data_in    in   [7:0] byte to queue
//   wr         in   write strobe, one byte offered per cycle while high
//   ps2_clk    out  PS/2 clock line (registered)
//   ps2_data   out  PS/2 data line (registered)
//   full       out  FIFO holds DEPTH bytes (registered)
//   empty      out  FIFO holds no bytes (registered)
//   overflow   out  sticky: a write was dropped because the FIFO was full
//   busy       out  a frame or the inter-frame gap is in progress
//   state_dbg  out  [1:0] current FSM state, for debug and checkers
//
// Write handshake: wr acts as valid and ~full as ready. A byte is accepted
// on any rising edge with wr=1 and full=0; with wr=1 and full=1 it is lost
// and overflow sets. full is the registered value, so a pop in the same
// cycle never makes room for that byte.
//
// Parameters: CLK_HALF >= 2, GAP >= 1, DEPTH a power of two >= 2.

module ps2_device_tx #(
   parameter int CLK_HALF = 8,
   parameter int GAP      = 16,
   parameter int DEPTH    = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] data_in,
   input  logic       wr,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       busy,
   output logic [1:0] state_dbg
);

   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_MAX = (2 * CLK_HALF > GAP) ? 2 * CLK_HALF : GAP;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_HALF - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_HALF - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
   localparam logic [AW:0]   DEPTH_V   = (AW + 1)'(DEPTH);
   localparam logic [3:0]    LAST_BIT  = 4'd10;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BIT  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   // FIFO storage and bookkeeping
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [AW:0]   count_n;
   logic          push;
   logic          pop;
   logic [7:0]    head;

   // Transmitter
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   // Bits still to be sent after the one currently on ps2_data, LSB next.
   logic [9:0]    frame_rest;

   always_comb begin
      push    = wr & ~full;
      pop     = (state == S_IDLE) & ~empty;
      head    = mem[rptr];
      count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      busy      = (state != S_IDLE);
      state_dbg = state;
   end

   // Storage needs no reset; a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (clrn && push) begin
         mem[wptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!clrn) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         overflow   <= 1'b0;
         state      <= S_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         frame_rest <= '0;
         ps2_clk    <= 1'b1;
         ps2_data   <= 1'b1;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         count <= count_n;
         full  <= (count_n == DEPTH_V);
         empty <= (count_n == '0);
         if (wr && full) begin
            overflow <= 1'b1;
         end

         case (state)
            S_IDLE: begin
               ps2_clk  <= 1'b1;
               ps2_data <= 1'b1;
               if (!empty) begin
                  // Start bit goes out immediately; the rest is shifted later.
                  state      <= S_BIT;
                  ps2_data   <= 1'b0;
                  frame_rest <= {1'b1, ~^head, head};
                  bit_idx    <= '0;
                  cnt        <= '0;
               end
            end

            S_BIT: begin
               if (cnt == BIT_LAST) begin
                  // End of a bit cell: raise the clock and present the next
                  // bit in the same cycle, so data only moves while clk is high.
                  cnt     <= '0;
                  ps2_clk <= 1'b1;
                  if (bit_idx == LAST_BIT) begin
                     state    <= S_GAP;
                     ps2_data <= 1'b1;
                  end else begin
                     bit_idx    <= bit_idx + 4'd1;
                     ps2_data   <= frame_rest[0];
                     frame_rest <= {1'b1, frame_rest[9:1]};
                  end
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt == HALF_LAST) begin
                     ps2_clk <= 1'b0;
                  end
               end
            end

            S_GAP: begin
               ps2_clk  <= 1'b1;
               ps2_data <= 1'b1;
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: begin
               state    <= S_IDLE;
               cnt      <= '0;
               ps2_clk  <= 1'b1;
               ps2_data <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx
//   Self-checking bench for ps2_device_tx. A reference model derives, from
//   the frame rules, the expected line levels for every cycle (offset from
//   the pop cycle -> bit cell, half phase), the FIFO flags and busy. A frame
//   decoder samples ps2_data on ps2_clk falling edges and compares each
//   received byte with the expected queue.

module tb_ps2_device_tx;

   localparam int CH    = 8;
   localparam int GAP   = 16;
   localparam int DEPTH = 8;
   localparam int FRAME = 22 * CH;

   // ---------------------------------------------------------------- clock/reset
   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] data_in;
   logic       wr;
   logic       ps2_clk;
   logic       ps2_data;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       busy;
   logic [1:0] state_dbg;

   always #5 clk = ~clk;

   ps2_device_tx #(.CLK_HALF(CH), .GAP(GAP), .DEPTH(DEPTH)) dut (
      .clk(clk), .clrn(clrn), .data_in(data_in), .wr(wr),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data), .full(full), .empty(empty),
      .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      else if (i <= 8) return b[i-1];
      else if (i == 9) return ~^b;
      else return 1'b1;
   endfunction

   // ---------------------------------------------------------------- reference model
   logic [7:0] m_q[$];      // bytes held in the FIFO
   logic [7:0] exp_q[$];    // bytes expected on the wire, in order
   logic       m_ovf = 1'b0;
   bit         m_active = 1'b0;
   logic [7:0] m_byte = 8'h00;
   int         pop_t = 0;
   int         next_pop = 0;
   int         cyc = 0;
   int         rst_count = 0;
   bit         chk_en = 1'b0;

   always @(posedge clk) begin
      cyc++;
      if (!clrn) begin
         // A frame whose stop-bit falling edge was not yet seen is lost.
         if (m_active && (cyc - 1 - pop_t) < 21 * CH && exp_q.size() > 0)
            void'(exp_q.pop_back());
         m_active = 1'b0;
         m_q.delete();
         m_ovf    = 1'b0;
         next_pop = 0;
         rst_count++;
      end else begin
         bit full_b;
         bit empty_b;
         full_b  = (m_q.size() == DEPTH);
         empty_b = (m_q.size() == 0);
         if (!empty_b && cyc >= next_pop) begin
            m_byte   = m_q.pop_front();
            exp_q.push_back(m_byte);
            pop_t    = cyc;
            m_active = 1'b1;
            next_pop = cyc + FRAME + GAP + 1;
         end
         if (wr) begin
            if (full_b) m_ovf = 1'b1;
            else m_q.push_back(data_in);
         end
      end
      chk_en = 1'b1;
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         int  o;
         logic e_clk;
         logic e_data;
         logic e_busy;
         o      = cyc - pop_t;
         e_clk  = 1'b1;
         e_data = 1'b1;
         if (m_active && o < FRAME) begin
            e_clk  = ((o % (2 * CH)) < CH);
            e_data = frame_bit(m_byte, o / (2 * CH));
         end
         e_busy = m_active && (o < FRAME + GAP);
         check_eq("ps2_clk",  32'(ps2_clk),  32'(e_clk));
         check_eq("ps2_data", 32'(ps2_data), 32'(e_data));
         check_eq("busy",     32'(busy),     32'(e_busy));
         check_eq("full",     32'(full),     32'(m_q.size() == DEPTH));
         check_eq("empty",    32'(empty),    32'(m_q.size() == 0));
         check_eq("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // ---------------------------------------------------------------- frame decoder
   logic [10:0] shreg = '0;
   int          nbits = 0;
   int          falls_total = 0;
   int          rx_count = 0;
   logic [7:0]  rx_last = 8'h00;
   logic        rx_last_par = 1'b0;
   logic        prev_clk = 1'b1;
   int          seen_rst = 0;
   int          hi_run = 0;
   bit          frame_done = 1'b0;
   int          gap_runs[$];
   int          busy_run = 0;
   int          last_busy_run = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         if (seen_rst != rst_count) begin
            seen_rst   = rst_count;
            nbits      = 0;
            frame_done = 1'b0;
            hi_run     = 0;
            busy_run   = 0;
         end
         if (prev_clk && !ps2_clk) begin
            shreg[nbits] = ps2_data;
            nbits++;
            falls_total++;
            if (nbits == 11) begin
               nbits = 0;
               check_eq("rx_start",  32'(shreg[0]),  32'(0));
               check_eq("rx_stop",   32'(shreg[10]), 32'(1));
               check_eq("rx_parity", 32'(shreg[9]),  32'(~^shreg[8:1]));
               if (exp_q.size() == 0) begin
                  check_eq("rx_unexpected", 32'(shreg[8:1]), 32'hFFFF_FFFF);
               end else begin
                  check_eq("rx_byte", 32'(shreg[8:1]), 32'(exp_q.pop_front()));
               end
               rx_last     = shreg[8:1];
               rx_last_par = shreg[9];
               rx_count++;
               frame_done  = 1'b1;
            end
         end
         prev_clk = ps2_clk;
         if (ps2_clk && ps2_data) begin
            hi_run++;
         end else begin
            if (hi_run > 0 && ps2_clk && frame_done) begin
               gap_runs.push_back(hi_run);
               frame_done = 1'b0;
            end
            hi_run = 0;
         end
         if (busy) begin
            busy_run++;
         end else begin
            if (busy_run > 0) last_busy_run = busy_run;
            busy_run = 0;
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic send(input logic [7:0] b);
      wr      = 1'b1;
      data_in = b;
      @(negedge clk);
      wr      = 1'b0;
   endtask

   task automatic do_reset();
      clrn = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
   endtask

   task automatic wait_quiet(input int budget);
      int n;
      n = 0;
      while ((busy || !empty) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("quiet_timeout", 32'(n < budget), 32'(1));
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int f0;
      int r0;
      logic [7:0] gbytes[3];
      clrn    = 1'b0;
      wr      = 1'b0;
      data_in = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_clk",   32'(ps2_clk),  32'(1));
      check_eq("rst_data",  32'(ps2_data), 32'(1));
      check_eq("rst_empty", 32'(empty),    32'(1));
      check_eq("rst_full",  32'(full),     32'(0));
      check_eq("rst_busy",  32'(busy),     32'(0));
      clrn = 1'b1;
      @(negedge clk);

      // Single byte 1C: 11 falling edges, busy for one frame plus the gap.
      f0 = falls_total;
      send(8'h1C);
      wait_quiet(1000);
      check_eq("1c_falls",    32'(falls_total - f0), 32'(11));
      check_eq("1c_byte",     32'(rx_last),          32'(8'h1C));
      check_eq("1c_parity",   32'(rx_last_par),      32'(0));
      check_eq("1c_busy_len", 32'(last_busy_run),    32'(176 + GAP));

      // Parity corner cases.
      send(8'hF0);
      wait_quiet(1000);
      check_eq("f0_byte",   32'(rx_last),     32'(8'hF0));
      check_eq("f0_parity", 32'(rx_last_par), 32'(1));
      send(8'h00);
      wait_quiet(1000);
      check_eq("00_byte",   32'(rx_last),     32'(8'h00));
      check_eq("00_parity", 32'(rx_last_par), 32'(1));

      // Overflow: bytes 1..10 on consecutive cycles; 10 is dropped.
      r0 = rx_count;
      for (int i = 1; i <= 9; i++) send(8'(i));
      check_eq("ovf_full_before", 32'(full),     32'(1));
      check_eq("ovf_before",      32'(overflow), 32'(0));
      send(8'd10);
      check_eq("ovf_after", 32'(overflow), 32'(1));
      wait_quiet(3000);
      check_eq("ovf_rx_count", 32'(rx_count - r0), 32'(9));
      check_eq("ovf_sticky",   32'(overflow),       32'(1));
      do_reset();
      check_eq("ovf_cleared", 32'(overflow), 32'(0));

      // Gap timing with three queued bytes.
      gap_runs.delete();
      gbytes[0] = 8'hE0; gbytes[1] = 8'hF0; gbytes[2] = 8'h1C;
      for (int i = 0; i < 3; i++) send(gbytes[i]);
      wait_quiet(2000);
      check_eq("gap_count", 32'(gap_runs.size()), 32'(2));
      for (int i = 0; i < gap_runs.size(); i++)
         check_eq("gap_len", 32'(gap_runs[i]), 32'(GAP + 1));

      // Reset during bit 4 with two bytes still queued.
      send(8'hA5); send(8'h3C); send(8'h7E);
      begin
         int n;
         n = 0;
         f0 = falls_total;
         while (falls_total - f0 < 5 && n < 400) begin
            @(negedge clk);
            n++;
         end
         check_eq("midrst_timeout", 32'(n < 400), 32'(1));
      end
      r0 = rx_count;
      f0 = falls_total;
      do_reset();
      check_eq("midrst_clk",   32'(ps2_clk),  32'(1));
      check_eq("midrst_data",  32'(ps2_data), 32'(1));
      check_eq("midrst_empty", 32'(empty),    32'(1));
      check_eq("midrst_ovf",   32'(overflow), 32'(0));
      repeat (400) @(negedge clk);
      check_eq("midrst_no_falls", 32'(falls_total - f0), 32'(0));
      check_eq("midrst_no_rx",    32'(rx_count - r0),    32'(0));

      // Randomized bursts, idle periods and occasional resets.
      for (int b = 0; b < 12; b++) begin
         int len;
         len = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            wr      = ($urandom_range(0, 3) != 0);
            data_in = 8'($urandom_range(0, 255));
            @(negedge clk);
         end
         wr = 1'b0;
         repeat ($urandom_range(0, 600)) @(negedge clk);
         if ($urandom_range(0, 5) == 0) do_reset();
      end
      wait_quiet(4000);
      check_eq("exp_q_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
